// File: rtl/frontend_cmd_pkg.sv
// Shared frontend command definitions used by every block that carries
// decoded commands between the frontend and the request path.
package frontend_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_NOP   = 4'h0,
        CMD_READ  = 4'h1,
        CMD_WRITE = 4'h2,
        CMD_FENCE = 4'h3,
        CMD_FLUSH = 4'h4
    } frontend_opcode_t;

    typedef struct packed {
        frontend_opcode_t opcode;
        logic [7:0]       tag;
        logic [19:0]      addr;
    } frontend_command_t;

    localparam int FRONTEND_CMD_W = $bits(frontend_command_t);

endpackage

// File: rtl/request_queue_pkg.sv
// Request queue constants and parameter-legality helpers; the payload type
// itself lives in the shared frontend command package.
package request_queue_pkg;

    localparam int DEPTH_LOG2_MIN = 1;
    localparam int DEPTH_LOG2_MAX = 8;

    function automatic bit depth_log2_legal(input int depth_log2);
        return (depth_log2 >= DEPTH_LOG2_MIN) && (depth_log2 <= DEPTH_LOG2_MAX);
    endfunction

    function automatic bit afull_legal(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

    function automatic bit aempty_legal(input int thresh, input int depth);
        return (thresh >= 0) && (thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/request_queue_mem.sv
// Storage for the request queue: one write port, one asynchronous read port,
// no reset, so it can be replaced by a register-file macro.
module request_queue_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers, and a reset here would prevent mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/request_queue.sv
// First-word-fall-through request queue with occupancy count, threshold
// flags, high-water mark and sticky overflow indication.
module request_queue
    import frontend_cmd_pkg::*;
    import request_queue_pkg::*;
#(
    parameter int DATA_WIDTH    = FRONTEND_CMD_W,
    parameter int DEPTH_LOG2    = 4,
    parameter int AFULL_THRESH  = (2**DEPTH_LOG2) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_rd_ready,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [DEPTH_LOG2:0]   o_high_water,
    output logic                  o_overflow
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

    localparam logic [PTR_W-1:0] ONE        = PTR_W'(1);
    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    if (!depth_log2_legal(DEPTH_LOG2)) begin : g_bad_depth
        $error("request_queue: DEPTH_LOG2=%0d outside 1..8", DEPTH_LOG2);
    end
    if (!afull_legal(AFULL_THRESH, DEPTH)) begin : g_bad_afull
        $error("request_queue: AFULL_THRESH=%0d outside 1..DEPTH", AFULL_THRESH);
    end
    if (!aempty_legal(AEMPTY_THRESH, DEPTH)) begin : g_bad_aempty
        $error("request_queue: AEMPTY_THRESH=%0d outside 0..DEPTH-1", AEMPTY_THRESH);
    end
    if (DATA_WIDTH < FRONTEND_CMD_W) begin : g_bad_width
        $error("request_queue: DATA_WIDTH=%0d cannot hold a frontend command", DATA_WIDTH);
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      count;
    logic [PTR_W-1:0]      count_next;
    logic [PTR_W-1:0]      high_water;
    logic                  overflow;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  rd_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

    assign wr_en  = i_wr_valid && !full;
    assign rd_en  = i_rd_ready && !empty;
    assign mem_we = wr_en && !i_rst && !i_flush;

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({wr_en, rd_en})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            high_water <= '0;
            overflow   <= 1'b0;
        end else if (i_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            high_water <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
            count <= count_next;
            if (count_next > high_water) begin
                high_water <= count_next;
            end
            if (i_wr_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    request_queue_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .clk   (i_clk),
        .we    (mem_we),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (i_wr_data),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (mem_rdata)
    );

    assign o_wr_ready     = !full;
    assign o_rd_valid     = !empty;
    assign o_rd_data      = mem_rdata;
    assign o_count        = count;
    assign o_almost_full  = (count >= AFULL_LVL);
    assign o_almost_empty = (count <= AEMPTY_LVL);
    assign o_high_water   = high_water;
    assign o_overflow     = overflow;

    a_count_bound : assert property (@(posedge i_clk) disable iff (i_rst)
        count <= PTR_W'(DEPTH));
    a_count_ptrs : assert property (@(posedge i_clk) disable iff (i_rst)
        count == PTR_W'(wr_ptr - rd_ptr));

endmodule
